// File: rtl/tilt_motion_pkg.sv
// Shared definitions for the tilt motion controller.
//   ACCEL_W        accelerometer sample width
//   OFF_W          signed offset width (one bit wider than a sample)
//   FILT_W         smoothing filter state width (sample scaled by 4)
//   SUM_W          calibration accumulator width
//   LEVEL_DEFAULT  zero-tilt level used after reset
//   state_t        top-level FSM encoding (ST_RUN, ST_CAL)
//   iir_step       one update of the optional smoothing filter
package tilt_motion_pkg;

    localparam int ACCEL_W       = 9;
    localparam int OFF_W         = 10;
    localparam int FILT_W        = 11;
    localparam int SUM_W         = 12;
    localparam int LEVEL_DEFAULT = 256;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_CAL = 1'b1
    } state_t;

    // f + (4*s - f) / 4 with the state held at 4x scale; the result always
    // lies between f and 4*s, so it never leaves the FILT_W range.
    function automatic logic [FILT_W-1:0] iir_step(input logic [FILT_W-1:0] f,
                                                   input logic [ACCEL_W-1:0] s);
        logic signed [FILT_W:0] diff;
        logic signed [FILT_W:0] upd;
        diff = $signed({1'b0, s, 2'b00}) - $signed({1'b0, f});
        upd  = $signed({1'b0, f}) + (diff >>> 2);
        return upd[FILT_W-1:0];
    endfunction

endpackage

// File: rtl/tilt_motion_ctrl_axis_stepper.sv
// axis_stepper: converts one axis sample into step pulses.
// Computes the signed offset from the level point, applies the deadzone,
// maps the tilt magnitude to a step period in ticks and counts ticks.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tick                one-cycle sample tick (sample/center valid)
//   hold                clears the counter and suppresses steps
//   sample, center      current axis sample and level point
//   step_inc, step_dec  combinational step request, valid only with tick
module axis_stepper
    import tilt_motion_pkg::*;
#(
    parameter int DEADZONE   = 16,
    parameter int PERIOD_MAX = 64,
    parameter int PERIOD_MIN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               hold,
    input  logic [ACCEL_W-1:0] sample,
    input  logic [ACCEL_W-1:0] center,
    output logic               step_inc,
    output logic               step_dec
);

    localparam int CNT_W = $clog2(PERIOD_MAX + 1);
    localparam int SPAN  = PERIOD_MAX - PERIOD_MIN;

    logic signed [OFF_W-1:0] off;
    logic [OFF_W-1:0]        mag;
    logic [OFF_W-1:0]        excess;
    logic [CNT_W-1:0]        period;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    dir_pos;
    logic                    active;
    logic                    sign_flip;
    logic                    reach;
    logic                    act_q;
    logic                    dir_q;

    always_comb begin
        off     = $signed({1'b0, sample}) - $signed({1'b0, center});
        mag     = off[OFF_W-1] ? OFF_W'(-off) : OFF_W'(off);
        dir_pos = ~off[OFF_W-1];
        active  = mag > OFF_W'(DEADZONE);
        // excess wraps when inactive; period is then unused
        excess  = mag - OFF_W'(DEADZONE);
        if (excess > OFF_W'(SPAN))
            period = CNT_W'(PERIOD_MIN);
        else
            period = CNT_W'(PERIOD_MAX) - CNT_W'(excess);
        // a direction change only counts if the previous tick was stepping
        sign_flip = act_q & (dir_q != dir_pos);
        cnt_inc   = cnt_q + CNT_W'(1);
        reach     = active & ~hold & ~sign_flip & (cnt_inc >= period);
        step_inc  = tick & reach & dir_pos;
        step_dec  = tick & reach & ~dir_pos;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            act_q <= 1'b0;
            dir_q <= 1'b0;
        end else if (tick) begin
            if (hold || !active) begin
                cnt_q <= '0;
                act_q <= 1'b0;
            end else begin
                act_q <= 1'b1;
                dir_q <= dir_pos;
                if (sign_flip || reach)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/tilt_motion_ctrl.sv
// tilt_motion_ctrl: tilt / pushbutton motion controller for the ball.
// Holds the sample-tick prescaler, the calibration FSM, button arbitration
// and the two axis steppers. Buttons always override tilt stepping.
// Build option: define TILT_SMOOTH_EN to pass samples through a first-order
// IIR smoothing filter before the offset calculation.
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   accel_x, accel_y              unsigned tilt samples, level nominally 256
//   tilt_en                       enables the tilt path
//   cal_req                       starts a level calibration
//   btn_xinc/xdec/yinc/ydec       debounced manual step requests
//   x_inc, x_dec, y_inc, y_dec    one-cycle step pulses
//   cal_busy                      calibration in progress
//   center_x, center_y            current level points
//
// state  | meaning
// ST_RUN | normal stepping, waiting for cal_req
// ST_CAL | averaging CAL_SAMPLES ticks to learn the level point
module tilt_motion_ctrl
    import tilt_motion_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int DEADZONE    = 16,
    parameter int PERIOD_MAX  = 64,
    parameter int PERIOD_MIN  = 4,
    parameter int CAL_SAMPLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ACCEL_W-1:0] accel_x,
    input  logic [ACCEL_W-1:0] accel_y,
    input  logic               tilt_en,
    input  logic               cal_req,
    input  logic               btn_xinc,
    input  logic               btn_xdec,
    input  logic               btn_yinc,
    input  logic               btn_ydec,
    output logic               x_inc,
    output logic               x_dec,
    output logic               y_inc,
    output logic               y_dec,
    output logic               cal_busy,
    output logic [ACCEL_W-1:0] center_x,
    output logic [ACCEL_W-1:0] center_y
);

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CAL_SHIFT = $clog2(CAL_SAMPLES);
    localparam int CAL_W     = (CAL_SHIFT > 0) ? CAL_SHIFT : 1;

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic               tick_d;
    state_t             state_q;
    state_t             state_d;
    logic               cal_start;
    logic               cal_done;
    logic [CAL_W-1:0]   cal_left;
    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
    logic [SUM_W-1:0]   sum_x_nxt;
    logic [SUM_W-1:0]   sum_y_nxt;
    logic [ACCEL_W-1:0] new_center_x;
    logic [ACCEL_W-1:0] new_center_y;
    logic [ACCEL_W-1:0] samp_x;
    logic [ACCEL_W-1:0] samp_y;
    logic               any_btn;
    logic               hold;
    logic               sx_inc;
    logic               sx_dec;
    logic               sy_inc;
    logic               sy_dec;

    // prescaler: tick is high for the single cycle at TICK_DIV-1
    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            tick_d   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            tick_d   <= tick;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (cal_req) state_d = ST_CAL;
            ST_CAL:  if (tick && cal_left == '0) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        cal_busy  = (state_q == ST_CAL);
        cal_start = (state_q == ST_RUN) && cal_req;
        cal_done  = (state_q == ST_CAL) && tick && (cal_left == '0);
    end

    assign sum_x_nxt    = sum_x + SUM_W'(accel_x);
    assign sum_y_nxt    = sum_y + SUM_W'(accel_y);
    assign new_center_x = sum_x_nxt[CAL_SHIFT +: ACCEL_W];
    assign new_center_y = sum_y_nxt[CAL_SHIFT +: ACCEL_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            cal_left <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            center_x <= ACCEL_W'(LEVEL_DEFAULT);
            center_y <= ACCEL_W'(LEVEL_DEFAULT);
        end else if (cal_start) begin
            cal_left <= CAL_W'(CAL_SAMPLES - 1);
            sum_x    <= '0;
            sum_y    <= '0;
        end else if (cal_busy && tick) begin
            if (cal_done) begin
                center_x <= new_center_x;
                center_y <= new_center_y;
            end else begin
                sum_x    <= sum_x_nxt;
                sum_y    <= sum_y_nxt;
                cal_left <= cal_left - CAL_W'(1);
            end
        end
    end

`ifdef TILT_SMOOTH_EN
    logic [FILT_W-1:0] filt_x;
    logic [FILT_W-1:0] filt_y;

    // reload at calibration end so the filter starts settled on the new level
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_x <= FILT_W'(LEVEL_DEFAULT * 4);
            filt_y <= FILT_W'(LEVEL_DEFAULT * 4);
        end else if (cal_done) begin
            filt_x <= {new_center_x, 2'b00};
            filt_y <= {new_center_y, 2'b00};
        end else if (tick) begin
            filt_x <= iir_step(filt_x, accel_x);
            filt_y <= iir_step(filt_y, accel_y);
        end
    end

    assign samp_x = filt_x[FILT_W-1:2];
    assign samp_y = filt_y[FILT_W-1:2];
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_x <= ACCEL_W'(LEVEL_DEFAULT);
            samp_y <= ACCEL_W'(LEVEL_DEFAULT);
        end else if (tick) begin
            samp_x <= accel_x;
            samp_y <= accel_y;
        end
    end
`endif

    assign any_btn = btn_xinc | btn_xdec | btn_yinc | btn_ydec;
    assign hold    = any_btn | ~tilt_en | cal_busy;

    axis_stepper #(
        .DEADZONE   (DEADZONE),
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_d),
        .hold     (hold),
        .sample   (samp_x),
        .center   (center_x),
        .step_inc (sx_inc),
        .step_dec (sx_dec)
    );

    axis_stepper #(
        .DEADZONE   (DEADZONE),
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_d),
        .hold     (hold),
        .sample   (samp_y),
        .center   (center_y),
        .step_inc (sy_inc),
        .step_dec (sy_dec)
    );

    // steppers run on tick_d so they see the sample registered on tick;
    // opposing buttons on one axis cancel
    always_ff @(posedge clk) begin
        if (reset) begin
            x_inc <= 1'b0;
            x_dec <= 1'b0;
            y_inc <= 1'b0;
            y_dec <= 1'b0;
        end else begin
            x_inc <= tick_d & (any_btn ? (btn_xinc & ~btn_xdec) : sx_inc);
            x_dec <= tick_d & (any_btn ? (btn_xdec & ~btn_xinc) : sx_dec);
            y_inc <= tick_d & (any_btn ? (btn_yinc & ~btn_ydec) : sy_inc);
            y_dec <= tick_d & (any_btn ? (btn_ydec & ~btn_yinc) : sy_dec);
        end
    end

endmodule

// File: tb/tb_tilt_motion_ctrl.sv
`timescale 1ns/1ps
module tb_tilt_motion_ctrl;

    localparam int TICK_DIV = 10;
    localparam int DZ       = 16;
    localparam int PMAX     = 64;
    localparam int PMIN     = 4;
    localparam int CALN     = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] accel_x = 9'd256;
    logic [8:0] accel_y = 9'd256;
    logic       tilt_en = 1'b1;
    logic       cal_req = 1'b0;
    logic       btn_xinc = 1'b0, btn_xdec = 1'b0, btn_yinc = 1'b0, btn_ydec = 1'b0;
    logic       x_inc, x_dec, y_inc, y_dec, cal_busy;
    logic [8:0] center_x, center_y;

    always #5 clk = ~clk;

    tilt_motion_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .accel_x  (accel_x),
        .accel_y  (accel_y),
        .tilt_en  (tilt_en),
        .cal_req  (cal_req),
        .btn_xinc (btn_xinc),
        .btn_xdec (btn_xdec),
        .btn_yinc (btn_yinc),
        .btn_ydec (btn_ydec),
        .x_inc    (x_inc),
        .x_dec    (x_dec),
        .y_inc    (y_inc),
        .y_dec    (y_dec),
        .cal_busy (cal_busy),
        .center_x (center_x),
        .center_y (center_y)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one update per clock edge, evaluated at the following
    // negedge with the inputs that were present at that edge
    int  m_phase, m_cal_n, m_sumx, m_sumy, m_sx, m_sy, m_cx, m_cy;
    bit  m_tickd, m_cal, m_valid = 1'b0;
    int  m_cnt[2];
    bit  m_act[2], m_dir[2];
    bit  e_xi, e_xd, e_yi, e_yd;
    int  c_xi, c_xd, c_yi, c_yd, c_busy, c_cal_steps;

    task automatic axis_eval(input int ax, input int s, input int c,
                             output bit inc, output bit dec);
        int off, mag, period, excess;
        inc = 1'b0;
        dec = 1'b0;
        off = s - c;
        mag = (off < 0) ? -off : off;
        if (mag <= DZ) begin
            m_cnt[ax] = 0;
            m_act[ax] = 1'b0;
        end else begin
            excess = mag - DZ;
            period = PMAX - ((excess < PMAX - PMIN) ? excess : PMAX - PMIN);
            if (m_act[ax] && (m_dir[ax] != (off > 0))) begin
                m_cnt[ax] = 0;
            end else begin
                m_cnt[ax]++;
                if (m_cnt[ax] >= period) begin
                    inc = (off > 0);
                    dec = (off < 0);
                    m_cnt[ax] = 0;
                end
            end
            m_act[ax] = 1'b1;
            m_dir[ax] = (off > 0);
        end
    endtask

    always @(negedge clk) begin
        bit is_tick, any, si, sd, ti, td;
        logic [22:0] dut_v, mod_v;
        if (reset) begin
            m_valid = 1'b1;
            m_phase = 0; m_tickd = 1'b0; m_cal = 1'b0; m_cal_n = 0;
            m_sumx = 0; m_sumy = 0; m_sx = 256; m_sy = 256; m_cx = 256; m_cy = 256;
            for (int a = 0; a < 2; a++) begin
                m_cnt[a] = 0; m_act[a] = 1'b0; m_dir[a] = 1'b0;
            end
            e_xi = 0; e_xd = 0; e_yi = 0; e_yd = 0;
        end else if (m_valid) begin
            e_xi = 0; e_xd = 0; e_yi = 0; e_yd = 0;
            if (m_tickd) begin
                any = btn_xinc | btn_xdec | btn_yinc | btn_ydec;
                if (any || !tilt_en || m_cal) begin
                    for (int a = 0; a < 2; a++) begin
                        m_cnt[a] = 0; m_act[a] = 1'b0;
                    end
                    if (any) begin
                        e_xi = btn_xinc && !btn_xdec;
                        e_xd = btn_xdec && !btn_xinc;
                        e_yi = btn_yinc && !btn_ydec;
                        e_yd = btn_ydec && !btn_yinc;
                    end
                end else begin
                    axis_eval(0, m_sx, m_cx, si, sd);
                    axis_eval(1, m_sy, m_cy, ti, td);
                    e_xi = si; e_xd = sd; e_yi = ti; e_yd = td;
                end
            end
            is_tick = (m_phase == TICK_DIV - 1);
            if (m_cal) begin
                if (is_tick) begin
                    m_sumx += int'(accel_x);
                    m_sumy += int'(accel_y);
                    m_cal_n++;
                    if (m_cal_n == CALN) begin
                        m_cx  = m_sumx / CALN;
                        m_cy  = m_sumy / CALN;
                        m_cal = 1'b0;
                    end
                end
            end else if (cal_req) begin
                m_cal = 1'b1; m_cal_n = 0; m_sumx = 0; m_sumy = 0;
            end
            if (is_tick) begin
                m_sx = int'(accel_x);
                m_sy = int'(accel_y);
            end
            m_tickd = is_tick;
            m_phase = is_tick ? 0 : m_phase + 1;
        end
        if (m_valid) begin
            dut_v = {x_inc, x_dec, y_inc, y_dec, cal_busy, center_x, center_y};
            mod_v = {e_xi, e_xd, e_yi, e_yd, m_cal, 9'(m_cx), 9'(m_cy)};
            check("outputs", int'(dut_v), int'(mod_v));
            check("x_excl", int'(x_inc & x_dec), 0);
            check("y_excl", int'(y_inc & y_dec), 0);
            c_xi += int'(x_inc); c_xd += int'(x_dec);
            c_yi += int'(y_inc); c_yd += int'(y_dec);
            c_busy += int'(cal_busy);
            if (cal_busy) c_cal_steps += int'(x_inc | x_dec | y_inc | y_dec);
        end
    end

    task automatic clear_counts();
        c_xi = 0; c_xd = 0; c_yi = 0; c_yd = 0; c_busy = 0; c_cal_steps = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // move to a mid-period cycle so input changes never straddle a tick
    task automatic sync_mid();
        do begin
            @(negedge clk);
            #1;
        end while (m_phase != 5);
    endtask

    task automatic pulse_cal();
        cal_req = 1'b1;
        @(negedge clk);
        #1;
        cal_req = 1'b0;
    endtask

    initial begin
        int k;
        bit found;

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("reset_center_x", int'(center_x), 256);
        check("reset_center_y", int'(center_y), 256);
        check("reset_cal_busy", int'(cal_busy), 0);
        check("reset_steps", int'({x_inc, x_dec, y_inc, y_dec}), 0);

        // level: no steps for 1000 ticks
        clear_counts();
        cycles(1000 * TICK_DIV);
        check("level_steps", c_xi + c_xd + c_yi + c_yd, 0);
        check("level_center_x", int'(center_x), 256);

        // strong +X tilt: fastest period
        sync_mid();
        accel_x = 9'd332;
        cycles(100);
        clear_counts();
        cycles(400);
        check("x332_inc_count", c_xi, 10);
        check("x332_dec_count", c_xd, 0);

        // small -Y tilt: slowest period, then sign flip
        sync_mid();
        accel_x = 9'd256;
        accel_y = 9'd236;
        cycles(700);
        clear_counts();
        cycles(1800);
        check("y236_dec_count", c_yd, 3);
        check("y236_inc_count", c_yi, 0);
        sync_mid();
        accel_y = 9'd276;
        clear_counts();
        k = 0; found = 1'b0;
        while (!found && k < 700) begin
            @(negedge clk);
            #1;
            k++;
            if (y_inc) found = 1'b1;
        end
        check("y_flip_latency", k, 606);
        check("y_flip_no_dec", c_yd, 0);

        // button overrides tilt
        sync_mid();
        accel_y = 9'd256;
        accel_x = 9'd400;
        btn_xdec = 1'b1;
        cycles(50);
        clear_counts();
        cycles(200);
        check("btn_xdec_count", c_xd, 20);
        check("btn_xinc_count", c_xi, 0);
        sync_mid();
        btn_xdec = 1'b0;
        clear_counts();
        k = 0; found = 1'b0;
        while (!found && k < 200) begin
            @(negedge clk);
            #1;
            k++;
            if (x_inc) found = 1'b1;
        end
        check("release_latency", k, 36);
        check("release_no_dec", c_xd, 0);

        // opposing buttons cancel
        sync_mid();
        btn_xinc = 1'b1;
        btn_xdec = 1'b1;
        clear_counts();
        cycles(200);
        check("both_btn_inc", c_xi, 0);
        check("both_btn_dec", c_xd, 0);
        sync_mid();
        btn_xinc = 1'b0;
        btn_xdec = 1'b0;

        // calibration
        accel_x = 9'd300;
        accel_y = 9'd200;
        cycles(100);
        sync_mid();
        clear_counts();
        pulse_cal();
        cycles(200);
        check("cal_busy_cycles", c_busy, 74);
        check("cal_tilt_steps", c_cal_steps, 0);
        check("cal_center_x", int'(center_x), 300);
        check("cal_center_y", int'(center_y), 200);
        clear_counts();
        cycles(500);
        check("post_cal_steps", c_xi + c_xd + c_yi + c_yd, 0);

        // reset in the middle of calibration
        sync_mid();
        accel_x = 9'd320;
        accel_y = 9'd180;
        pulse_cal();
        cycles(30);
        check("midcal_busy", int'(cal_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_cal_busy", int'(cal_busy), 0);
        check("abort_center_x", int'(center_x), 256);
        check("abort_center_y", int'(center_y), 256);
        reset = 1'b0;

        // randomized segments against the model
        repeat (150) begin
            sync_mid();
            if ($urandom_range(0, 3) == 0) accel_x = 9'($urandom_range(0, 511));
            else                           accel_x = 9'($urandom_range(180, 340));
            if ($urandom_range(0, 3) == 0) accel_y = 9'($urandom_range(0, 511));
            else                           accel_y = 9'($urandom_range(180, 340));
            tilt_en  = ($urandom_range(0, 7) != 0);
            btn_xinc = ($urandom_range(0, 9) == 0);
            btn_xdec = ($urandom_range(0, 9) == 0);
            btn_yinc = ($urandom_range(0, 9) == 0);
            btn_ydec = ($urandom_range(0, 9) == 0);
            cal_req  = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            #1;
            cal_req = 1'b0;
            reset   = 1'b0;
            cycles(TICK_DIV * int'($urandom_range(1, 30)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "timeout");
    end

endmodule
